// File: rtl/divider_8by4_pkg.sv
// Shared definitions for the sequential restoring divider.
package divider_8by4_pkg;

  // 2'd3 is never entered; the FSM decodes it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int N_DEF = 8;
  localparam int M_DEF = 4;

  // Iteration counter width; guarded so a 1-bit dividend still gets a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: compare the partial remainder against the
// divisor and subtract when it fits.
module divider_step #(
  parameter int M = 4
) (
  input  logic [M:0]   T,
  input  logic [M-1:0] D,
  output logic [M-1:0] R_next,
  output logic         qbit
);

  // T < 2*D after the shift, so T - D always fits back into M bits.
  always_comb begin
    qbit   = (T >= {1'b0, D});
    R_next = qbit ? M'(T - {1'b0, D}) : T[M-1:0];
  end

endmodule

// File: rtl/divider_8by4.sv
// Sequential restoring divider: one quotient bit per clock behind a
// START/BUSY/DONE handshake. Divide-by-zero finishes immediately.
module divider_8by4
  import divider_8by4_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [N-1:0] DIVIDEND,
  input  logic [M-1:0] DIVISOR,
  output logic [N-1:0] QUOTIENT,
  output logic [M-1:0] REMAINDER,
  output logic         BUSY,
  output logic         DONE,
  output logic         DIV_BY_ZERO
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   qsh_q, qsh_d;
  logic [M-1:0]   r_q, r_d;
  logic [M-1:0]   d_q, d_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [M-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [M:0]     t_w;
  logic [M-1:0]   r_next_w;
  logic           qbit_w;

  // Shift the next dividend bit into the partial remainder.
  assign t_w = {r_q, qsh_q[N-1]};

  divider_step #(.M(M)) u_step (
    .T      (t_w),
    .D      (d_q),
    .R_next (r_next_w),
    .qbit   (qbit_w)
  );

  // Next-state, datapath and result updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qsh_d   = qsh_q;
    r_d     = r_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (DIVISOR != '0) begin
            state_d = ST_RUN;
            qsh_d   = DIVIDEND;
            r_d     = '0;
            d_d     = DIVISOR;
            cnt_d   = '0;
          end else begin
            state_d = ST_DONE;
            quot_d  = '1;
            rem_d   = '1;
            dbz_d   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        qsh_d = {qsh_q[N-2:0], qbit_w};
        r_d   = r_next_w;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          quot_d  = {qsh_q[N-2:0], qbit_w};
          rem_d   = r_next_w;
          dbz_d   = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; RST aborts any operation without a DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      qsh_q   <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qsh_q   <= qsh_d;
      r_q     <= r_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign QUOTIENT    = quot_q;
  assign REMAINDER   = rem_q;
  assign DIV_BY_ZERO = dbz_q;
  assign BUSY        = (state_q == ST_RUN);
  assign DONE        = (state_q == ST_DONE);

endmodule

// File: tb/tb_divider_8by4.sv
// Bench for divider_8by4: table of directed divides, multi-cycle corner
// sequences and an exhaustive sweep, checked through an expectation queue.
module tb_divider_8by4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [7:0] DIVIDEND = '0;
  logic [3:0] DIVISOR = '0;
  logic [7:0] QUOTIENT;
  logic [3:0] REMAINDER;
  logic       BUSY, DONE, DIV_BY_ZERO;

  divider_8by4 #(.N(8), .M(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
    .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER), .BUSY(BUSY), .DONE(DONE),
    .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int dvd, dvs, q, r, dbz;
  } exp_t;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    int q, r, dbz, lat, busy;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every DONE pops one expectation; a DONE with nothing queued is an error.
  always @(negedge CLK) begin
    if (!RST && DONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", int'(QUOTIENT), e.q);
        chk("remainder", int'(REMAINDER), e.r);
        chk("div_by_zero", int'(DIV_BY_ZERO), e.dbz);
        if (e.dvs != 0) begin
          chk("q*d+r", int'(QUOTIENT) * e.dvs + int'(REMAINDER), e.dvd);
          chk("r<d", int'(int'(REMAINDER) < e.dvs), 1);
        end
      end
    end
  end

  // One-cycle START; returns at the negedge of the first cycle after acceptance.
  task automatic start_op(input logic [7:0] dvd, input logic [3:0] dvs,
                          input int q, input int r, input int dbz);
    exp_t e;
    @(negedge CLK);
    START = 1'b1; DIVIDEND = dvd; DIVISOR = dvs;
    e.dvd = int'(dvd); e.dvs = int'(dvs); e.q = q; e.r = r; e.dbz = dbz;
    sb.push_back(e);
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Count cycles until DONE (bounded), and BUSY cycles on the way.
  task automatic wait_done(input int exp_lat, input int exp_busy);
    int lat = 1;
    int busy = 0;
    while (!DONE && lat < 40) begin
      if (BUSY) busy++;
      @(negedge CLK);
      lat++;
    end
    chk("done_latency", lat, exp_lat);
    chk("busy_cycles", busy, exp_busy);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'd200, 4'd7,  28,  4,  0, 9, 8};
    vecs[1] = '{8'd225, 4'd15, 15,  0,  0, 9, 8};
    vecs[2] = '{8'd255, 4'd1,  255, 0,  0, 9, 8};
    vecs[3] = '{8'd5,   4'd9,  0,   5,  0, 9, 8};
    vecs[4] = '{8'd77,  4'd0,  255, 15, 1, 1, 0};
    vecs[5] = '{8'd10,  4'd3,  3,   1,  0, 9, 8};

    // Reset held for two cycles.
    repeat (2) @(negedge CLK);
    chk("rst_quotient", int'(QUOTIENT), 0);
    chk("rst_remainder", int'(REMAINDER), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_dbz", int'(DIV_BY_ZERO), 0);
    RST = 1'b0;

    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dbz);
      wait_done(vecs[i].lat, vecs[i].busy);
    end

    // START and new operands while busy must be ignored.
    start_op(8'd100, 4'd6, 16, 4, 0);
    START = 1'b1; DIVIDEND = 8'd50; DIVISOR = 4'd3;
    @(negedge CLK);
    START = 1'b0; DIVIDEND = 8'd0; DIVISOR = 4'd0;
    wait_done(8, 7);
    repeat (12) @(negedge CLK);

    // Reset on the 4th BUSY cycle aborts the divide with no DONE.
    start_op(8'd180, 4'd11, 16, 4, 0);
    repeat (3) @(negedge CLK);
    chk("busy_before_abort", int'(BUSY), 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    sb.delete();
    chk("abort_quotient", int'(QUOTIENT), 0);
    chk("abort_remainder", int'(REMAINDER), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(DONE), 0);
    chk("abort_dbz", int'(DIV_BY_ZERO), 0);
    repeat (12) @(negedge CLK);
    start_op(8'd180, 4'd11, 16, 4, 0);
    wait_done(9, 8);

    // Every nonzero operand pair back-to-back at minimum spacing.
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        start_op(8'(a), 4'(b), a / b, a % b, 0);
        wait_done(9, 8);
      end
    end

    @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
